// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory fetch sequencer: fetch PC, prefetch FIFO and decode valid/ready handshake.
// Define IMEM_DBG_PORT_EN to share the read port with a debug requester via round-robin arbitration.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        dbg_req,
  input  logic [31:0] dbg_addr,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata
);

  localparam int               PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = FIFO_DEPTH[PTR_W:0];
  localparam logic [PTR_W:0]   CNT_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

  logic [31:0]      fetch_pc;
  logic [31:0]      fifo_pc    [FIFO_DEPTH];
  logic [31:0]      fifo_instr [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             pop;
  logic             fetch_want;
  logic             fetch_gnt;

  assign out_valid  = (count != '0);
  assign pop        = out_valid & out_ready;
  assign fetch_want = ~redirect_valid & ((count < FULL_CNT) | pop);
  assign out_pc     = out_valid ? fifo_pc[rd_ptr]    : '0;
  assign out_instr  = out_valid ? fifo_instr[rd_ptr] : '0;

`ifdef IMEM_DBG_PORT_EN
  // rr_last    | meaning
  // RR_FETCH   | last port grant went to fetch; debug wins the next tie
  // RR_DBG     | last port grant went to debug; fetch wins the next tie
  typedef enum logic {RR_FETCH = 1'b0, RR_DBG = 1'b1} rr_e;
  rr_e rr_last;

  always_comb begin
    fetch_gnt = 1'b0;
    dbg_gnt   = 1'b0;
    if (fetch_want && dbg_req) begin
      if (rr_last == RR_FETCH) dbg_gnt   = 1'b1;
      else                     fetch_gnt = 1'b1;
    end else begin
      fetch_gnt = fetch_want;
      dbg_gnt   = dbg_req;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last    <= RR_FETCH;
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= '0;
    end else begin
      if (fetch_gnt)    rr_last <= RR_FETCH;
      else if (dbg_gnt) rr_last <= RR_DBG;
      dbg_rvalid <= dbg_gnt;
      if (dbg_gnt) dbg_rdata <= imem_rdata;
    end
  end

  assign imem_addr = dbg_gnt ? {dbg_addr[31:2], 2'b00} : fetch_pc;

  logic unused_bits;
  assign unused_bits = ^{redirect_pc[1:0], dbg_addr[1:0]};
`else
  assign fetch_gnt  = fetch_want;
  assign dbg_gnt    = 1'b0;
  assign dbg_rvalid = 1'b0;
  assign dbg_rdata  = '0;
  assign imem_addr  = fetch_pc;

  logic unused_bits;
  assign unused_bits = ^{redirect_pc[1:0], dbg_req, dbg_addr};
`endif

  // Redirect flushes by resetting pointers; stale storage is masked by count.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (fetch_gnt) begin
        fetch_pc <= fetch_pc + 32'd4;
        wr_ptr   <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({fetch_gnt, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && fetch_gnt) begin
      fifo_pc[wr_ptr]    <= fetch_pc;
      fifo_instr[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl; debug-port checks follow IMEM_DBG_PORT_EN.
module tb_imem_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_instr;
  logic        dbg_req;
  logic [31:0] dbg_addr;
  logic        dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_rdata;

  logic [31:0] w_addr, w_rdata, w_pc, w_instr, w_dbg_rdata;
  logic        w_valid, w_ready, w_dbg_gnt, w_dbg_rvalid;
  logic        w_zero;
  logic [31:0] w_zero32;

  int n_cmp;
  int n_bad;
  logic [63:0] exp_q[$];
  logic [63:0] wq[$];
  logic [63:0] e, we;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return {18'd0, a[15:2]};
  endfunction

  assign imem_rdata = mem_rd(imem_addr);
  assign w_rdata    = mem_rd(w_addr);
  assign w_ready    = 1'b1;
  assign w_zero     = 1'b0;
  assign w_zero32   = '0;

  imem_fetch_ctrl u_dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata)
  );

  imem_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .reset(reset), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .redirect_valid(w_zero), .redirect_pc(w_zero32),
    .out_valid(w_valid), .out_ready(w_ready), .out_pc(w_pc), .out_instr(w_instr),
    .dbg_req(w_zero), .dbg_addr(w_zero32), .dbg_gnt(w_dbg_gnt),
    .dbg_rvalid(w_dbg_rvalid), .dbg_rdata(w_dbg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every accepted head entry must match the next expected one.
  always @(negedge clk) begin
    if (!reset && !redirect_valid && out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL deliver_unexpected: got pc=%h instr=%h, none expected", out_pc, out_instr);
      end else begin
        e = exp_q.pop_front();
        if ({out_pc, out_instr} !== e) begin
          n_bad++;
          $display("FAIL deliver: got pc=%h instr=%h want pc=%h instr=%h",
                   out_pc, out_instr, e[63:32], e[31:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && w_valid && wq.size() != 0) begin
      we = wq.pop_front();
      n_cmp++;
      if ({w_pc, w_instr} !== we) begin
        n_bad++;
        $display("FAIL wrap_deliver: got pc=%h instr=%h want pc=%h instr=%h",
                 w_pc, w_instr, we[63:32], we[31:0]);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input logic [31:0] pc, input logic [31:0] ins);
    exp_q.push_back({pc, ins});
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s: got %0d entries undelivered want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    dbg_req = 1'b0; dbg_addr = '0;
    wq.push_back({32'hFFFF_FFF8, 32'h0000_3FFE});
    wq.push_back({32'hFFFF_FFFC, 32'h0000_3FFF});
    wq.push_back({32'h0000_0000, 32'h0000_0000});

    repeat (2) step();
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
    chk("rst_dbg_rvalid", {31'd0, dbg_rvalid}, 32'd0);
    chk("rst_dbg_rdata", dbg_rdata, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);

    step();
    exp_push(32'h0, 32'h0); exp_push(32'h4, 32'h1);
    exp_push(32'h8, 32'h2); exp_push(32'hC, 32'h3);
    reset = 1'b0;
    @(negedge clk);
    chk("first_cycle_empty", {31'd0, out_valid}, 32'd0);
    chk("first_fetch_addr", imem_addr, 32'h0);
    drain("stream");

    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      chk("stall_head_pc", out_pc, 32'h10);
    end
    chk("stall_fetch_pc", imem_addr, 32'h18);
    chk("stall_valid", {31'd0, out_valid}, 32'd1);

    step();
    exp_push(32'h10, 32'h4); exp_push(32'h14, 32'h5); exp_push(32'h18, 32'h6);
    out_ready = 1'b1;
    drain("resume");
    out_ready = 1'b0;
    step();
    @(negedge clk);
    chk("full_fetch_pc", imem_addr, 32'h24);
    chk("full_head_pc", out_pc, 32'h1C);

    exp_push(32'h100, 32'h40); exp_push(32'h104, 32'h41);
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h102; out_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir_flush_valid", {31'd0, out_valid}, 32'd0);
    chk("redir_flush_pc", out_pc, 32'd0);
    chk("redir_fetch_addr", imem_addr, 32'h100);
    drain("redirect");
    out_ready = 1'b0;
    step();
    step();
    @(negedge clk);
    chk("refill_fetch_pc", imem_addr, 32'h110);
    chk("refill_head_pc", out_pc, 32'h108);

    exp_push(32'h108, 32'h42); exp_push(32'h10C, 32'h43);
    exp_push(32'h110, 32'h44); exp_push(32'h114, 32'h45);
    step();
    out_ready = 1'b1; dbg_req = 1'b1; dbg_addr = 32'h203;
    @(negedge clk);
`ifdef IMEM_DBG_PORT_EN
    chk("arb1_dbg_gnt", {31'd0, dbg_gnt}, 32'd1);
    chk("arb1_addr", imem_addr, 32'h200);
`else
    chk("arb1_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
    chk("arb1_addr", imem_addr, 32'h110);
`endif
    step();
    @(negedge clk);
`ifdef IMEM_DBG_PORT_EN
    chk("arb2_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
    chk("arb2_addr", imem_addr, 32'h110);
    chk("arb2_rvalid", {31'd0, dbg_rvalid}, 32'd1);
    chk("arb2_rdata", dbg_rdata, 32'h80);
`else
    chk("arb2_rvalid", {31'd0, dbg_rvalid}, 32'd0);
    chk("arb2_rdata", dbg_rdata, 32'd0);
`endif
    step();
    @(negedge clk);
`ifdef IMEM_DBG_PORT_EN
    chk("arb3_dbg_gnt", {31'd0, dbg_gnt}, 32'd1);
`else
    chk("arb3_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
`endif
    step();
    dbg_req = 1'b0;
    @(negedge clk);
`ifdef IMEM_DBG_PORT_EN
    chk("arb4_rvalid", {31'd0, dbg_rvalid}, 32'd1);
    chk("arb4_rdata", dbg_rdata, 32'h80);
`else
    chk("arb4_rvalid", {31'd0, dbg_rvalid}, 32'd0);
`endif
    drain("dbg_share");
    out_ready = 1'b0;

    repeat (3) step();
    @(negedge clk);
    chk("prefill_valid", {31'd0, out_valid}, 32'd1);
    step();
    reset = 1'b1; dbg_req = 1'b1; dbg_addr = 32'h10;
    @(negedge clk);
`ifdef IMEM_DBG_PORT_EN
    chk("rst_cycle_dbg_gnt", {31'd0, dbg_gnt}, 32'd1);
`else
    chk("rst_cycle_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
`endif
    step();
    reset = 1'b0; dbg_req = 1'b0;
    exp_push(32'h0, 32'h0); exp_push(32'h4, 32'h1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_pc", out_pc, 32'd0);
    chk("mid_rst_rvalid", {31'd0, dbg_rvalid}, 32'd0);
    chk("mid_rst_addr", imem_addr, 32'h0);
    drain("post_reset");
    out_ready = 1'b0;

    chk("wrap_remaining", wq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish before 100000");
    $fatal(1);
  end

endmodule
